// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer.
// State encoding and a constant-width helper.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int unsigned clog2(
    input int unsigned v
  );
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_prescale_tick.sv
// Prescaler: one tick every PRESCALE enabled cycles.
// Holds its phase while en is low; clr restarts it.
module prescale_tick
  import countdown_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = clog2(PRESCALE);
  localparam int unsigned PW = (CW < 1) ? 1 : CW;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause FSM and done pulse.
// Optional auto-reload makes it a periodic tick source.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cnt_eff;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  assign pre_en  = (state_q == ST_RUN) & ~pause;
  assign pre_clr = (state_q == ST_IDLE);

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // A same-cycle load decides whether start may proceed.
  assign cnt_eff = load ? load_val : count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end
        if (start && cnt_eff != '0)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (auto_reload && reload_q != '0) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      ST_HOLD: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end
        if (start && !pause)
          state_d = (cnt_eff == '0) ? ST_IDLE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share stimulus.
// A behavioural model predicts outputs; a monitor compares.
module tb_countdown_timer;

  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         zero;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;

  logic [W-1:0] cnt1, cnt4;
  logic         busy1, busy4;
  logic         done1, done4;
  logic         zero1, zero4;

  int n_chk  = 0;
  int n_fail = 0;

  obs_t exp1[$];
  obs_t exp4[$];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load(load),
    .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload),
    .count(cnt1), .busy(busy1),
    .done(done1), .zero(zero1)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .load(load),
    .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload),
    .count(cnt4), .busy(busy4),
    .done(done4), .zero(zero4)
  );

  // Reference model: mode 0 idle, 1 counting, 2 paused.
  int m_mode[2];
  int m_cnt[2];
  int m_rel[2];
  int m_ph[2];
  bit m_done[2];

  task automatic model_step(input int i, input int p);
    m_done[i] = 0;
    if (rst) begin
      m_mode[i] = 0; m_cnt[i] = 0;
      m_rel[i] = 0;  m_ph[i] = 0;
      return;
    end
    case (m_mode[i])
      0: begin
        if (load) begin
          m_cnt[i] = load_val; m_rel[i] = load_val;
        end
        if (start && m_cnt[i] > 0) begin
          m_mode[i] = 1; m_ph[i] = 0;
        end
      end
      1: begin
        if (pause) m_mode[i] = 2;
        else begin
          m_ph[i] += 1;
          if (m_ph[i] == p) begin
            m_ph[i] = 0;
            m_cnt[i] -= 1;
            if (m_cnt[i] == 0) begin
              m_done[i] = 1;
              if (auto_reload && m_rel[i] > 0)
                m_cnt[i] = m_rel[i];
              else
                m_mode[i] = 0;
            end
          end
        end
      end
      default: begin
        if (load) begin
          m_cnt[i] = load_val; m_rel[i] = load_val;
        end
        if (start && !pause)
          m_mode[i] = (m_cnt[i] > 0) ? 1 : 0;
      end
    endcase
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.cnt  = W'(m_cnt[i]);
    o.busy = (m_mode[i] != 0);
    o.done = m_done[i];
    o.zero = (m_cnt[i] == 0);
    return o;
  endfunction

  task automatic cyc(
    input bit r, input bit ld, input int lv,
    input bit st, input bit ps, input bit ar
  );
    @(negedge clk);
    rst = r; load = ld; load_val = W'(lv);
    start = st; pause = ps; auto_reload = ar;
    model_step(0, 1);
    model_step(1, 4);
    exp1.push_back(model_obs(0));
    exp4.push_back(model_obs(1));
  endtask

  task automatic idle(input int n, input bit ar);
    repeat (n) cyc(0, 0, 0, 0, 0, ar);
  endtask

  task automatic check(
    input string nm, input obs_t a, input obs_t e
  );
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got cnt=%0d busy=%b done=%b zero=%b want cnt=%0d busy=%b done=%b zero=%b",
        nm, $time, a.cnt, a.busy, a.done, a.zero,
        e.cnt, e.busy, e.done, e.zero);
    end
  endtask

  // Monitor: compares after every edge with a pending prediction.
  always @(posedge clk) begin
    #1;
    if (exp1.size() > 0)
      check("pre1", {cnt1, busy1, done1, zero1}, exp1.pop_front());
    if (exp4.size() > 0)
      check("pre4", {cnt4, busy4, done4, zero4}, exp4.pop_front());
  end

  initial begin
    // reset, then start with count 0
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    // load+start 5
    cyc(0, 1, 5, 1, 0, 0);
    idle(24, 0);
    // load 3 then start
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(16, 0);
    // pause, load in hold, resume
    cyc(0, 1, 6, 1, 0, 0);
    idle(2, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(12, 0);
    // hold with load 0, then start returns idle
    cyc(0, 1, 4, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(3, 0);
    // auto-reload periodic, then release
    cyc(0, 1, 2, 1, 0, 1);
    idle(12, 1);
    idle(12, 0);
    // reload of 1: continuous done
    cyc(0, 1, 1, 1, 0, 1);
    idle(6, 1);
    idle(6, 0);
    // load ignored in RUN, reset mid-run
    cyc(0, 1, 4, 1, 0, 0);
    cyc(0, 1, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4, 0);
    // random phase
    for (int k = 0; k < 3000; k++) begin
      bit r, ld, st, ps, ar;
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 7) == 0);
      ar = (k / 200) % 2 == 1;
      cyc(r, ld, $urandom_range(0, 7), st, ps, ar);
    end
    idle(2, 0);
    @(negedge clk);
    n_chk++;
    if (exp1.size() != 0 || exp4.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending want 0",
        exp1.size(), exp4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
